// File: rtl/position_ctrl_if.sv
// Bundle of button inputs and cursor/selection outputs for position_ctrl.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or a single-cycle strobe.
interface position_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_hold;
  logic [3:0] pos;
  logic [3:0] sel_pos;
  logic       sel_valid;
  logic       sel_pulse;
  logic       clr_pulse;
  logic       internal_reset;

  // Button/debouncer side: drives the buttons, observes the controller.
  modport master (
    output btn_left, btn_right, btn_hold,
    input  pos, sel_pos, sel_valid, sel_pulse, clr_pulse, internal_reset
  );

  // Controller side.
  modport slave (
    input  btn_left, btn_right, btn_hold,
    output pos, sel_pos, sel_valid, sel_pulse, clr_pulse, internal_reset
  );
endinterface

// File: rtl/position_ctrl.sv
// Cursor over N_POS positions; short press of hold confirms, long press clears.
// Latency: every output is registered, one cycle after the sampled input.
// No backpressure: inputs are single-cycle pulses/levels and are never stalled.
module position_ctrl #(
  parameter int          N_POS      = 8,
  parameter logic [31:0] LONG_PRESS = 32'd50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  position_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] LONG  = 2'd2;

  localparam logic [3:0] POS_MAX = 4'(N_POS - 1);

  logic [1:0]  state;
  logic [31:0] press_cnt;
  logic [3:0]  pos_q;
  logic [3:0]  sel_pos_q;
  logic        sel_valid_q;
  logic        sel_pulse_q;
  logic        clr_pulse_q;
  logic        internal_reset_q;
  logic [3:0]  pos_step;

  // Candidate cursor value from left/right pulses, with wrap; both together cancel.
  always_comb begin
    pos_step = pos_q;
    if (bus.btn_left && !bus.btn_right) begin
      pos_step = (pos_q == 4'd0) ? POS_MAX : pos_q - 4'd1;
    end else if (bus.btn_right && !bus.btn_left) begin
      pos_step = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
    end
  end

  // Press FSM, press-length counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      press_cnt        <= 32'd0;
      pos_q            <= 4'd0;
      sel_pos_q        <= 4'd0;
      sel_valid_q      <= 1'b0;
      sel_pulse_q      <= 1'b0;
      clr_pulse_q      <= 1'b0;
      internal_reset_q <= 1'b0;
    end else begin
      sel_pulse_q      <= 1'b0;
      clr_pulse_q      <= 1'b0;
      internal_reset_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.btn_hold) begin
            // Cursor buttons are frozen while confirm is held.
            state     <= PRESS;
            press_cnt <= 32'd1;
          end else begin
            pos_q <= pos_step;
          end
        end
        PRESS: begin
          if (!bus.btn_hold) begin
            state <= IDLE;
            if (press_cnt < LONG_PRESS) begin
              sel_pos_q   <= pos_q;
              sel_valid_q <= 1'b1;
              sel_pulse_q <= 1'b1;
            end
          end else if (press_cnt == LONG_PRESS - 32'd1) begin
            // This edge samples the LONG_PRESS-th consecutive high cycle.
            state            <= LONG;
            press_cnt        <= LONG_PRESS;
            pos_q            <= 4'd0;
            sel_pos_q        <= 4'd0;
            sel_valid_q      <= 1'b0;
            clr_pulse_q      <= 1'b1;
            internal_reset_q <= 1'b1;
          end else if (press_cnt < LONG_PRESS) begin
            press_cnt <= press_cnt + 32'd1;
          end
        end
        LONG: begin
          // Release after a clear produces no confirm.
          if (!bus.btn_hold) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pos            = pos_q;
  assign bus.sel_pos        = sel_pos_q;
  assign bus.sel_valid      = sel_valid_q;
  assign bus.sel_pulse      = sel_pulse_q;
  assign bus.clr_pulse      = clr_pulse_q;
  assign bus.internal_reset = internal_reset_q;

endmodule

// File: tb/tb_position_ctrl.sv
// Self-checking bench for position_ctrl (N_POS=8, LONG_PRESS=10).
// Directed scenarios followed by randomized buttons and presses, all scored
// against a run-length based reference model of the button behaviour.
module tb_position_ctrl;

  localparam int NP = 8;
  localparam int LP = 10;

  logic clk;
  logic rst_n;

  position_ctrl_if bus ();

  position_ctrl #(
    .N_POS      (NP),
    .LONG_PRESS (32'd10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cursor, last selection, and how many consecutive
  // high samples of btn_hold the current press has seen (0 = no press).
  int pos_m, selp_m, selv_m, run_m;
  bit sp_m, cp_m;

  // Pulse bookkeeping for scenario-level checks.
  int cyc_idx, sel_cnt, clr_cnt, clr_at;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos_m = 0; selp_m = 0; selv_m = 0; run_m = 0; sp_m = 0; cp_m = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit h);
    sp_m = 0;
    cp_m = 0;
    if (h) begin
      if (run_m < LP) begin
        run_m++;
        if (run_m == LP) begin
          cp_m = 1; pos_m = 0; selp_m = 0; selv_m = 0;
        end
      end
    end else begin
      if (run_m == 0) begin
        if (l && !r)      pos_m = (pos_m + NP - 1) % NP;
        else if (r && !l) pos_m = (pos_m + 1) % NP;
      end else if (run_m < LP) begin
        sp_m = 1; selp_m = pos_m; selv_m = 1;
      end
      run_m = 0;
    end
  endtask

  task automatic compare_all();
    chk("pos",       bus.pos,            pos_m);
    chk("sel_pos",   bus.sel_pos,        selp_m);
    chk("sel_valid", bus.sel_valid,      selv_m);
    chk("sel_pulse", bus.sel_pulse,      sp_m);
    chk("clr_pulse", bus.clr_pulse,      cp_m);
    chk("int_rst",   bus.internal_reset, cp_m);
    chk("excl",      bus.sel_pulse & bus.clr_pulse, 0);
    if (bus.sel_pulse === 1'b1) sel_cnt++;
    if (bus.clr_pulse === 1'b1) begin clr_cnt++; clr_at = cyc_idx; end
  endtask

  task automatic clr_counts();
    cyc_idx = 0; sel_cnt = 0; clr_cnt = 0; clr_at = -1;
  endtask

  // One clock: drive at negedge, model the rising edge, sample 1 ns later.
  task automatic cyc(input bit l, input bit r, input bit h);
    @(negedge clk);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_hold  = h;
    @(posedge clk);
    model_step(l, r, h);
    #1;
    cyc_idx++;
    compare_all();
  endtask

  task automatic hold_for(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_hold = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int hold_left;
  bit rl, rr, rh;

  initial begin
    rst_n = 1'b0;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_hold = 0;
    model_reset();
    clr_counts();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Right x3, then left x4 wrapping through 0.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("r3_pos", bus.pos, 3);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    chk("l4_wrap_pos", bus.pos, 7);

    // 7 -> 0 on right; simultaneous pulses at 2 cancel.
    cyc(0, 1, 0);
    chk("wrap_right_pos", bus.pos, 0);
    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk("both_pos", bus.pos, 2);

    // Short press at 5, with a right pulse ignored mid-press.
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    clr_counts();
    cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("short_sel_cnt", sel_cnt, 1);
    chk("short_sel_pos", bus.sel_pos, 5);
    chk("short_sel_valid", bus.sel_valid, 1);
    chk("short_pos_kept", bus.pos, 5);

    // Long press at 3: clear exactly once, right after the 10th high sample.
    cyc(1, 0, 0); cyc(1, 0, 0);
    chk("pre_long_pos", bus.pos, 3);
    clr_counts();
    hold_for(15);
    cyc(0, 0, 0);
    chk("long_clr_cnt", clr_cnt, 1);
    chk("long_clr_at", clr_at, LP);
    chk("long_sel_cnt", sel_cnt, 0);
    chk("long_pos", bus.pos, 0);
    chk("long_sel_valid", bus.sel_valid, 0);

    // Boundary: 9 highs confirm, 10 highs clear.
    cyc(0, 1, 0);
    clr_counts();
    hold_for(LP - 1);
    cyc(0, 0, 0);
    chk("b9_sel_cnt", sel_cnt, 1);
    chk("b9_clr_cnt", clr_cnt, 0);
    chk("b9_sel_pos", bus.sel_pos, 1);
    clr_counts();
    hold_for(LP);
    cyc(0, 0, 0);
    chk("b10_clr_cnt", clr_cnt, 1);
    chk("b10_sel_cnt", sel_cnt, 0);

    // Reset during the 6th cycle of a press aborts it.
    cyc(0, 1, 0); cyc(0, 1, 0);
    clr_counts();
    hold_for(5);
    @(negedge clk);
    bus.btn_hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_sel_cnt", sel_cnt, 0);
    chk("rst_clr_cnt", clr_cnt, 0);
    chk("rst_pos", bus.pos, 0);
    bus.btn_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    hold_for(3);
    cyc(0, 0, 0);
    chk("post_rst_sel_pulse", bus.sel_pulse, 1);
    chk("post_rst_sel_pos", bus.sel_pos, 0);
    chk("post_rst_sel_cnt", sel_cnt, 1);

    // Randomized phase.
    hold_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        hold_left = 0;
      end
      if (hold_left == 0 && $urandom_range(0, 7) == 0)
        hold_left = $urandom_range(1, 14);
      rh = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      rl = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 3) == 0);
      cyc(rl, rr, rh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/position_ctrl.md
POSITION_CTRL -- requirements
Module: position_ctrl

Interface
REQ-001 Parameter N_POS, default 8, number of selectable positions (legal range 2..16).
REQ-002 Parameter LONG_PRESS, default 50_000_000, consecutive btn_hold-high cycles that constitute a long press (legal range 2..2^32-1).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_left  input  1  one-cycle synchronised pulse from the left-button pulse debouncer.
REQ-006 btn_right  input  1  one-cycle synchronised pulse from the right-button pulse debouncer.
REQ-007 btn_hold  input  1  synchronised level from the confirm-button continuous debouncer.
REQ-008 pos  output  4  current cursor position, 0..N_POS-1.
REQ-009 sel_pos  output  4  last confirmed position.
REQ-010 sel_valid  output  1  high while sel_pos holds a confirmed value.
REQ-011 sel_pulse  output  1  one-cycle strobe on short-press confirm.
REQ-012 clr_pulse  output  1  one-cycle strobe on long-press clear.
REQ-013 internal_reset  output  1  one-cycle flush to the confirm-button continuous debouncer, coincident with clr_pulse.

Function
REQ-014 FSM states SHALL be IDLE, PRESS, LONG; all outputs registered.
REQ-015 In IDLE with btn_hold=0: btn_left alone decrements pos, btn_right alone increments pos; the new value is visible the cycle after the pulse is sampled.
REQ-016 Wrap-around: pos=N_POS-1 with btn_right -> 0; pos=0 with btn_left -> N_POS-1.
REQ-017 btn_left and btn_right sampled high together SHALL leave pos unchanged.
REQ-018 btn_left/btn_right SHALL be ignored while btn_hold=1 or state is not IDLE.
REQ-019 IDLE -> PRESS when btn_hold sampled 1; the 32-bit press counter loads 1 on that edge.
REQ-020 In PRESS with btn_hold=1: counter increments, saturating at LONG_PRESS.
REQ-021 PRESS with btn_hold=0 and counter < LONG_PRESS -> IDLE; on the same edge sel_pos<=pos, sel_valid<=1, sel_pulse<=1 for one cycle.
REQ-022 PRESS with btn_hold=1 and counter = LONG_PRESS-1 -> LONG; on the same edge pos<=0, sel_pos<=0, sel_valid<=0, clr_pulse<=1, internal_reset<=1, each for one cycle; clr_pulse is therefore high in the cycle after btn_hold has been sampled high LONG_PRESS consecutive times.
REQ-023 LONG -> IDLE on the first cycle btn_hold is sampled 0; no sel_pulse is generated on that release.
REQ-024 A btn_hold rise after returning to IDLE SHALL start a fresh press (counter reloads to 1).
REQ-025 sel_pulse and clr_pulse SHALL never be high in the same cycle.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, counter=0, pos=0, sel_pos=0, sel_valid=0, sel_pulse=0, clr_pulse=0, internal_reset=0.
REQ-027 Reset asserted mid-press SHALL abort the press with no sel_pulse or clr_pulse; operation resumes on the first edge after rst_n deasserts.

Verification (N_POS=8, LONG_PRESS=10)
REQ-028 Reset, then 3 btn_right pulses -> pos=3; then 4 btn_left pulses -> pos=7 (wrap through 0).
REQ-029 pos=7, btn_right -> pos=0; btn_left and btn_right together at pos=2 -> pos stays 2.
REQ-030 pos=5, btn_hold high 4 cycles then low -> one sel_pulse, sel_pos=5, sel_valid=1; btn_right while btn_hold=1 -> pos unchanged.
REQ-031 sel_valid=1, pos=3, btn_hold high 15 cycles -> clr_pulse and internal_reset high exactly once, in the cycle after the 10th sampled-high cycle; pos=0, sel_valid=0; no sel_pulse on release.
REQ-032 btn_hold high 9 cycles then low -> sel_pulse, no clr_pulse (boundary); btn_hold high 10 cycles -> clr_pulse, no sel_pulse.
REQ-033 rst_n pulsed low during the 6th cycle of a press -> no strobes, all outputs 0; the next 3-cycle press after reset -> sel_pulse with sel_pos=0.
